// File: rtl/peripheral_bus_pkg.sv
// Shared types and constants for the peripheral bus arbiter.
// Defines arbiter state encoding, bus widths and the timeout read value.
package peripheral_bus_pkg;

  localparam int PBUS_ADDR_W = 16;
  localparam int PBUS_DATA_W = 32;
  localparam int PBUS_SEL_W  = 4;

  localparam logic [PBUS_DATA_W-1:0] TIMEOUT_READ_VALUE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } pbus_state_e;

endpackage

// File: rtl/peripheral_bus_timeout.sv
// Busy-cycle counter for the arbiter ACCESS state.
// Ports: clk, rst (sync, active high), clear, count in; expired out
// (high on the busy cycle that reaches TIMEOUT_CYCLES).
module peripheral_bus_timeout #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired = count && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/peripheral_bus_arbiter.sv
// Round-robin arbiter sharing the peripheral bus between m0 and m1.
// Ports: clk, rst (sync, active high); per master request/we/address/
// byteSelect/dataWrite in, ack/error/dataRead out; registered
// peripheralBus_* outputs, peripheralBus_dataRead/busy in.
// Build macro PERIPHERAL_BUS_ARBITER_TIMEOUT_EN adds the busy timeout
// and the TIMEOUT_CYCLES parameter.
module peripheral_bus_arbiter
  import peripheral_bus_pkg::*;
`ifdef PERIPHERAL_BUS_ARBITER_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 16
)
`endif
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   m0_request,
  input  logic                   m0_we,
  input  logic [PBUS_ADDR_W-1:0] m0_address,
  input  logic [PBUS_SEL_W-1:0]  m0_byteSelect,
  input  logic [PBUS_DATA_W-1:0] m0_dataWrite,
  output logic                   m0_ack,
  output logic                   m0_error,
  output logic [PBUS_DATA_W-1:0] m0_dataRead,
  input  logic                   m1_request,
  input  logic                   m1_we,
  input  logic [PBUS_ADDR_W-1:0] m1_address,
  input  logic [PBUS_SEL_W-1:0]  m1_byteSelect,
  input  logic [PBUS_DATA_W-1:0] m1_dataWrite,
  output logic                   m1_ack,
  output logic                   m1_error,
  output logic [PBUS_DATA_W-1:0] m1_dataRead,
  output logic                   peripheralEnable,
  output logic                   peripheralBus_we,
  output logic                   peripheralBus_oe,
  output logic [PBUS_ADDR_W-1:0] peripheralBus_address,
  output logic [PBUS_SEL_W-1:0]  peripheralBus_byteSelect,
  output logic [PBUS_DATA_W-1:0] peripheralBus_dataWrite,
  input  logic [PBUS_DATA_W-1:0] peripheralBus_dataRead,
  input  logic                   peripheralBus_busy
);

  pbus_state_e            state_q, state_d;
  logic                   grant_q, grant_d;
  logic                   last_grant_q, last_grant_d;
  logic                   we_q, we_d;
  logic [PBUS_ADDR_W-1:0] addr_q, addr_d;
  logic [PBUS_SEL_W-1:0]  sel_q, sel_d;
  logic [PBUS_DATA_W-1:0] wdata_q, wdata_d;
  logic [PBUS_DATA_W-1:0] rdata_q, rdata_d;
  logic                   timed_out;

`ifdef PERIPHERAL_BUS_ARBITER_TIMEOUT_EN
  logic err_q, err_d;

  // Idle clears the counter, so each access starts from zero.
  peripheral_bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == ST_IDLE),
    .count  ((state_q == ST_ACCESS) && peripheralBus_busy),
    .expired(timed_out)
  );
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    sel_d        = sel_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
`ifdef PERIPHERAL_BUS_ARBITER_TIMEOUT_EN
    err_d        = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (m0_request || m1_request) begin
          // Tie goes to whoever was not served last.
          grant_d = (m0_request && m1_request) ? ~last_grant_q
                                               : m1_request;
          we_d    = grant_d ? m1_we         : m0_we;
          addr_d  = grant_d ? m1_address    : m0_address;
          sel_d   = grant_d ? m1_byteSelect : m0_byteSelect;
          wdata_d = grant_d ? m1_dataWrite  : m0_dataWrite;
          state_d = ST_ACCESS;
`ifdef PERIPHERAL_BUS_ARBITER_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      ST_ACCESS: begin
        if (!peripheralBus_busy) begin
          rdata_d = peripheralBus_dataRead;
          state_d = ST_RESPOND;
        end else if (timed_out) begin
          rdata_d = TIMEOUT_READ_VALUE;
          state_d = ST_RESPOND;
`ifdef PERIPHERAL_BUS_ARBITER_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end
      end
      ST_RESPOND: begin
        last_grant_d = grant_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      sel_q        <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
`ifdef PERIPHERAL_BUS_ARBITER_TIMEOUT_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      sel_q        <= sel_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
`ifdef PERIPHERAL_BUS_ARBITER_TIMEOUT_EN
      err_q        <= err_d;
`endif
    end
  end

  logic respond;
  assign respond = (state_q == ST_RESPOND);

  assign peripheralEnable         = (state_q == ST_ACCESS);
  assign peripheralBus_we         = peripheralEnable &  we_q;
  assign peripheralBus_oe         = peripheralEnable & ~we_q;
  assign peripheralBus_address    = addr_q;
  assign peripheralBus_byteSelect = sel_q;
  assign peripheralBus_dataWrite  = wdata_q;

  assign m0_ack      = respond & ~grant_q;
  assign m1_ack      = respond &  grant_q;
  assign m0_dataRead = m0_ack ? rdata_q : '0;
  assign m1_dataRead = m1_ack ? rdata_q : '0;

`ifdef PERIPHERAL_BUS_ARBITER_TIMEOUT_EN
  assign m0_error = m0_ack & err_q;
  assign m1_error = m1_ack & err_q;
`else
  assign m0_error = 1'b0;
  assign m1_error = 1'b0;
`endif

endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// Directed self-checking bench for peripheral_bus_arbiter.
// Covers read, stalled write, round-robin, reset abort, timeout, drop.
module tb_peripheral_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_request, m0_we, m1_request, m1_we;
  logic [15:0] m0_address, m1_address;
  logic [3:0]  m0_byteSelect, m1_byteSelect;
  logic [31:0] m0_dataWrite, m1_dataWrite;
  logic        m0_ack, m0_error, m1_ack, m1_error;
  logic [31:0] m0_dataRead, m1_dataRead;
  logic        pen, pwe, poe;
  logic [15:0] paddr;
  logic [3:0]  psel;
  logic [31:0] pwdata, prdata;
  logic        pbusy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

`ifdef PERIPHERAL_BUS_ARBITER_TIMEOUT_EN
  peripheral_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
`else
  peripheral_bus_arbiter dut (
`endif
    .clk                     (clk),
    .rst                     (rst),
    .m0_request              (m0_request),
    .m0_we                   (m0_we),
    .m0_address              (m0_address),
    .m0_byteSelect           (m0_byteSelect),
    .m0_dataWrite            (m0_dataWrite),
    .m0_ack                  (m0_ack),
    .m0_error                (m0_error),
    .m0_dataRead             (m0_dataRead),
    .m1_request              (m1_request),
    .m1_we                   (m1_we),
    .m1_address              (m1_address),
    .m1_byteSelect           (m1_byteSelect),
    .m1_dataWrite            (m1_dataWrite),
    .m1_ack                  (m1_ack),
    .m1_error                (m1_error),
    .m1_dataRead             (m1_dataRead),
    .peripheralEnable        (pen),
    .peripheralBus_we        (pwe),
    .peripheralBus_oe        (poe),
    .peripheralBus_address   (paddr),
    .peripheralBus_byteSelect(psel),
    .peripheralBus_dataWrite (pwdata),
    .peripheralBus_dataRead  (prdata),
    .peripheralBus_busy      (pbusy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0_request = 0; m0_we = 0; m0_address = 0;
    m0_byteSelect = 0; m0_dataWrite = 0;
    m1_request = 0; m1_we = 0; m1_address = 0;
    m1_byteSelect = 0; m1_dataWrite = 0;
    prdata = 0; pbusy = 0;
    tick(); tick();
    checks++;
    if ({pen, pwe, poe, m0_ack, m1_ack, m0_error, m1_error} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 0",
               {pen, pwe, poe, m0_ack, m1_ack, m0_error, m1_error});
    end
    checks++;
    if ({paddr, psel, pwdata, m0_dataRead, m1_dataRead} !== '0) begin
      errors++;
      $display("FAIL reset_data got %h/%h/%h exp 0", paddr, psel, pwdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read();
    m0_request = 1; m0_we = 0; m0_address = 16'h1004;
    m0_byteSelect = 4'hF; prdata = 32'hCAFEF00D; pbusy = 0;
    tick();
    checks++;
    if ({pen, poe, pwe, m0_ack} !== 4'b1100 || paddr !== 16'h1004) begin
      errors++;
      $display("FAIL read_access got en/oe/we/ack=%b addr=%h exp 1100 1004",
               {pen, poe, pwe, m0_ack}, paddr);
    end
    tick();
    checks++;
    if (m0_ack !== 1'b1 || m0_dataRead !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL read_ack got ack=%b data=%h exp 1 cafef00d",
               m0_ack, m0_dataRead);
    end
    checks++;
    if ({pen, m1_ack, m0_error} !== 3'b0 || m1_dataRead !== 32'h0) begin
      errors++;
      $display("FAIL read_respond_side got %b %h exp 000 0",
               {pen, m1_ack, m0_error}, m1_dataRead);
    end
    m0_request = 0;
    prdata = 0;
    tick();
    checks++;
    if ({pen, m0_ack} !== 2'b00 || m0_dataRead !== 32'h0) begin
      errors++;
      $display("FAIL read_idle got en/ack=%b data=%h exp 00 0",
               {pen, m0_ack}, m0_dataRead);
    end
  endtask

  task automatic test_write_busy();
    m1_request = 1; m1_we = 1; m1_address = 16'h2010;
    m1_byteSelect = 4'b0011; m1_dataWrite = 32'h12345678; pbusy = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({pen, pwe, poe, m1_ack} !== 4'b1100 || paddr !== 16'h2010 ||
          psel !== 4'b0011 || pwdata !== 32'h12345678) begin
        errors++;
        $display("FAIL write_stall[%0d] got %b %h %b %h exp 1100 2010 0011 12345678",
                 i, {pen, pwe, poe, m1_ack}, paddr, psel, pwdata);
      end
      if (i == 3) pbusy = 0;
      tick();
    end
    checks++;
    if ({m1_ack, m0_ack, pen, m1_error} !== 4'b1000) begin
      errors++;
      $display("FAIL write_ack got ack1/ack0/en/err=%b exp 1000",
               {m1_ack, m0_ack, pen, m1_error});
    end
    m1_request = 0; m1_we = 0;
    tick();
    checks++;
    if (m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL write_idle got ack=%b exp 0", m1_ack);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] order;
    order = 3'b010;
    m0_request = 1; m0_we = 0; m0_address = 16'h3000;
    m1_request = 1; m1_we = 0; m1_address = 16'h4000;
    prdata = 32'h0BAD_BEEF; pbusy = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (paddr !== (order[i] ? 16'h4000 : 16'h3000) || pen !== 1'b1) begin
        errors++;
        $display("FAIL rr_grant[%0d] got addr=%h en=%b exp %h 1",
                 i, paddr, pen, order[i] ? 16'h4000 : 16'h3000);
      end
      tick();
      checks++;
      if ({m0_ack, m1_ack} !== {~order[i], order[i]}) begin
        errors++;
        $display("FAIL rr_ack[%0d] got m0/m1=%b exp %b",
                 i, {m0_ack, m1_ack}, {~order[i], order[i]});
      end
      if (i == 2) begin
        m0_request = 0;
        m1_request = 0;
      end
      tick();
    end
    checks++;
    if ({pen, m0_ack, m1_ack} !== 3'b000) begin
      errors++;
      $display("FAIL rr_idle got %b exp 000", {pen, m0_ack, m1_ack});
    end
    prdata = 0;
  endtask

  task automatic test_reset_mid();
    m0_request = 1; m0_we = 0; m0_address = 16'h1100; pbusy = 1;
    tick();
    tick();
    rst = 1; m0_request = 0;
    tick();
    checks++;
    if ({pen, m0_ack, m1_ack, m0_error} !== 4'b0) begin
      errors++;
      $display("FAIL rst_mid got en/ack0/ack1/err=%b exp 0000",
               {pen, m0_ack, m1_ack, m0_error});
    end
    rst = 0; pbusy = 0;
    tick();
    checks++;
    if ({pen, m0_ack, m1_ack} !== 3'b0) begin
      errors++;
      $display("FAIL rst_after got %b exp 000", {pen, m0_ack, m1_ack});
    end
    m1_request = 1; m1_we = 0; m1_address = 16'h5008;
    prdata = 32'hA5A5_5A5A;
    tick();
    checks++;
    if (pen !== 1'b1 || poe !== 1'b1 || paddr !== 16'h5008) begin
      errors++;
      $display("FAIL rst_m1_access got en=%b oe=%b addr=%h exp 1 1 5008",
               pen, poe, paddr);
    end
    tick();
    checks++;
    if (m1_ack !== 1'b1 || m1_dataRead !== 32'hA5A5_5A5A || m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL rst_m1_ack got ack=%b data=%h ack0=%b exp 1 a5a55a5a 0",
               m1_ack, m1_dataRead, m0_ack);
    end
    m1_request = 0; prdata = 0;
    tick();
  endtask

  task automatic test_timeout();
    int acks;
    m0_request = 1; m0_we = 0; m0_address = 16'h6000; pbusy = 1;
    prdata = 32'h1234_0000;
    tick();
`ifdef PERIPHERAL_BUS_ARBITER_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pen !== 1'b1 || m0_ack !== 1'b0) begin
        errors++;
        $display("FAIL to_wait[%0d] got en=%b ack=%b exp 1 0", i, pen, m0_ack);
      end
      tick();
    end
    checks++;
    if ({m0_ack, m0_error} !== 2'b11 || m0_dataRead !== 32'hFFFF_FFFF ||
        pen !== 1'b0) begin
      errors++;
      $display("FAIL to_error got ack/err=%b data=%h en=%b exp 11 ffffffff 0",
               {m0_ack, m0_error}, m0_dataRead, pen);
    end
    m0_request = 0; pbusy = 0;
    tick();
`else
    acks = 0;
    for (int i = 0; i < 100; i++) begin
      if (m0_ack || m1_ack) acks++;
      tick();
    end
    checks++;
    if (acks !== 0 || pen !== 1'b1) begin
      errors++;
      $display("FAIL to_stuck got acks=%0d en=%b exp 0 1", acks, pen);
    end
    pbusy = 0; m0_request = 0;
    tick();
    checks++;
    if (m0_ack !== 1'b1 || m0_error !== 1'b0 || m0_dataRead !== 32'h1234_0000) begin
      errors++;
      $display("FAIL to_release got ack=%b err=%b data=%h exp 1 0 12340000",
               m0_ack, m0_error, m0_dataRead);
    end
    tick();
`endif
    prdata = 0;
  endtask

  task automatic test_drop();
    int acks;
    acks = 0;
    m0_request = 1; m0_we = 0; m0_address = 16'h7000; pbusy = 1;
    prdata = 32'h7777_0001;
    tick();
    m0_request = 0;
    tick();
    checks++;
    if (pen !== 1'b1 || m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL drop_hold got en=%b ack=%b exp 1 0", pen, m0_ack);
    end
    pbusy = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (m0_ack) acks++;
      if (i == 0) begin
        checks++;
        if (m0_ack !== 1'b1 || m0_dataRead !== 32'h7777_0001) begin
          errors++;
          $display("FAIL drop_ack got ack=%b data=%h exp 1 77770001",
                   m0_ack, m0_dataRead);
        end
      end
    end
    checks++;
    if (acks !== 1 || pen !== 1'b0) begin
      errors++;
      $display("FAIL drop_once got acks=%0d en=%b exp 1 0", acks, pen);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_busy();
    test_round_robin();
    test_reset_mid();
    test_timeout();
    test_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
